// File: rtl/mfp_heartbeat_pkg.sv
// Shared definitions for the heartbeat capture front end.
//   hb_record_t : layout of one queued record, {seq, flags, interval_ms}
//   hb_state_e  : beat-detection state machine encodings
//   make_flags  : packs the record flag byte from its individual causes
package mfp_heartbeat_pkg;

  // Flag bit indices inside the record flag byte; bits 7:3 are reserved (zero).
  localparam int unsigned FLAG_TIMEOUT    = 0;
  localparam int unsigned FLAG_PRIOR_DROP = 1;
  localparam int unsigned FLAG_SAT        = 2;

  // Beat LED on-time in ms and the counter width needed to hold it.
  localparam int unsigned LED_MS = 50;
  localparam int unsigned LED_W  = 6;

  typedef struct packed {
    logic [7:0]  seq;
    logic [7:0]  flags;
    logic [15:0] interval_ms;
  } hb_record_t;

  typedef enum logic [1:0] {
    StWaitFirst = 2'd0,
    StRefract   = 2'd1,
    StArmed     = 2'd2
  } hb_state_e;

  function automatic logic [7:0] make_flags(input logic timeout, input logic prior_drop,
                                            input logic sat);
    logic [7:0] flags;
    flags                  = 8'h00;
    flags[FLAG_TIMEOUT]    = timeout;
    flags[FLAG_PRIOR_DROP] = prior_drop;
    flags[FLAG_SAT]        = sat;
    return flags;
  endfunction

endpackage

// File: rtl/mfp_sync_fifo.sv
// Synchronous FIFO with a registered head output.
//   i_clk, i_rst : clock, synchronous active-high reset (flushes the queue, head reads 0)
//   i_push/i_wdata : write request and data; dropped when full unless a pop happens too
//   i_pop        : read request; ignored when empty
//   o_rdata      : registered queue head, 0 while empty
//   o_full/o_empty : occupancy flags from the extended pointers
module mfp_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic [WIDTH-1:0] r_head;

  logic             w_full;
  logic             w_empty;
  logic             w_pop_ok;
  logic             w_push_ok;
  logic [AW:0]      w_wr_next;
  logic [AW:0]      w_rd_next;
  logic [WIDTH-1:0] w_head_next;

  // Extra pointer MSB distinguishes full from empty when the addresses match.
  assign w_empty   = (r_wr == r_rd);
  assign w_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop_ok  = i_pop & ~w_empty;
  // Pop frees a slot first, so a push into a full queue with a pop is accepted.
  assign w_push_ok = i_push & (~w_full | w_pop_ok);
  assign w_wr_next = r_wr + {{AW{1'b0}}, w_push_ok};
  assign w_rd_next = r_rd + {{AW{1'b0}}, w_pop_ok};

  always_comb begin
    w_head_next = '0;
    if (w_rd_next == w_wr_next) begin
      w_head_next = '0;
    end else if (w_rd_next == r_wr) begin
      // New head is the entry being written this cycle; bypass the memory.
      w_head_next = i_wdata;
    end else begin
      w_head_next = r_mem[w_rd_next[AW-1:0]];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr[AW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_head <= '0;
    end else begin
      r_wr   <= w_wr_next;
      r_rd   <= w_rd_next;
      r_head <= w_head_next;
    end
  end

  assign o_rdata = r_head;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/mfp_heartbeat_capture.sv
// Heart-rate sensor front end: measures beat-to-beat intervals in ms and queues records.
//   HCLK, HRESET  : clock, synchronous active-high reset
//   SENSOR_PULSE  : raw asynchronous sensor pulse
//   IO_HEARTBEAT  : queue head {seq[31:24], flags[23:16], interval_ms[15:0]}
//   IO_READ_RDY   : queue not empty
//   IO_READ_ACK   : CPU acknowledge level; each rising edge pops one record
//   BEAT_LED      : stretched beat indicator
//   OVERFLOW      : sticky record-dropped flag, cleared by the next accepted push
module mfp_heartbeat_capture
  import mfp_heartbeat_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned REFRACT_MS = 250,
  parameter int unsigned TIMEOUT_MS = 3000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        SENSOR_PULSE,
  output logic [31:0] IO_HEARTBEAT,
  output logic        IO_READ_RDY,
  input  logic        IO_READ_ACK,
  output logic        BEAT_LED,
  output logic        OVERFLOW
);

  localparam int unsigned TICK_CYCLES = CLK_HZ / 1000;
  localparam int unsigned PW          = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CYCLES - 1);
  localparam logic [15:0]   REFRACT_V = 16'(REFRACT_MS);
  localparam logic [15:0]   TIMEOUT_V = 16'(TIMEOUT_MS);

  // Input path
  logic r_sync1;
  logic r_sync2;
  logic r_sync_prev;
  logic r_rise;
  logic r_ack_prev;
  logic w_ack_rise;

  // Timing
  logic [PW-1:0]    r_presc;
  logic             w_tick;
  logic [15:0]      r_interval;
  logic [15:0]      w_interval_d;
  logic [LED_W-1:0] r_led_cnt;

  // Control
  hb_state_e  r_state;
  hb_state_e  w_state_d;
  logic       w_beat;
  logic       w_timeout;
  logic       w_push;
  logic       w_pop;
  logic       w_drop;
  logic [7:0] r_seq;
  logic       r_overflow;
  hb_record_t w_record;

  // FIFO status
  logic [31:0] w_head;
  logic        w_full;
  logic        w_empty;

  // Two-stage synchroniser followed by a registered rise detector.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync_prev <= 1'b0;
      r_rise      <= 1'b0;
      r_ack_prev  <= 1'b0;
    end else begin
      r_sync1     <= SENSOR_PULSE;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
      r_rise      <= r_sync2 & ~r_sync_prev;
      r_ack_prev  <= IO_READ_ACK;
    end
  end

  assign w_ack_rise = IO_READ_ACK & ~r_ack_prev;

  // Free-running ms prescaler.
  assign w_tick = (r_presc == PRESC_MAX);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Beat detection state machine.
  always_comb begin
    w_state_d = r_state;
    w_beat    = 1'b0;
    w_timeout = 1'b0;
    w_push    = 1'b0;
    case (r_state)
      StWaitFirst: begin
        if (r_rise) begin
          w_beat    = 1'b1;
          w_state_d = StRefract;
        end
      end
      StRefract: begin
        if (r_interval == TIMEOUT_V) begin
          w_timeout = 1'b1;
          w_push    = 1'b1;
          w_state_d = StWaitFirst;
        end else if (r_interval >= REFRACT_V) begin
          w_state_d = StArmed;
        end
      end
      StArmed: begin
        // A beat coinciding with the timeout takes priority.
        if (r_rise) begin
          w_beat    = 1'b1;
          w_push    = 1'b1;
          w_state_d = StRefract;
        end else if (r_interval == TIMEOUT_V) begin
          w_timeout = 1'b1;
          w_push    = 1'b1;
          w_state_d = StWaitFirst;
        end
      end
      default: begin
        w_state_d = StWaitFirst;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= StWaitFirst;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Interval counter: saturates rather than wrapping so a stale interval stays recognisable.
  always_comb begin
    w_interval_d = r_interval;
    if (w_beat || w_timeout) begin
      w_interval_d = '0;
    end else if (w_tick && (r_interval != 16'hFFFF)) begin
      w_interval_d = r_interval + 16'd1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_interval <= '0;
    end else begin
      r_interval <= w_interval_d;
    end
  end

  // Record assembly and queue bookkeeping.
  assign w_record.seq         = r_seq;
  assign w_record.flags       = make_flags(w_timeout, r_overflow, (r_interval == 16'hFFFF));
  assign w_record.interval_ms = w_timeout ? TIMEOUT_V : r_interval;

  assign w_pop  = w_ack_rise & ~w_empty;
  assign w_drop = w_push & w_full & ~w_pop;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_seq      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        // Sequence advances even for a dropped record so the CPU can spot the gap.
        r_seq <= r_seq + 8'd1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (w_push) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Beat LED stretcher, restarted by every accepted beat.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_led_cnt <= '0;
    end else if (w_beat) begin
      r_led_cnt <= LED_W'(LED_MS);
    end else if (w_tick && (r_led_cnt != '0)) begin
      r_led_cnt <= r_led_cnt - 1'b1;
    end
  end

  mfp_sync_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk  (HCLK),
    .i_rst  (HRESET),
    .i_push (w_push),
    .i_wdata(w_record),
    .i_pop  (w_ack_rise),
    .o_rdata(w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  assign IO_HEARTBEAT = w_head;
  assign IO_READ_RDY  = ~w_empty;
  assign BEAT_LED     = (r_led_cnt != '0);
  assign OVERFLOW     = r_overflow;

endmodule

// File: tb/tb_mfp_heartbeat_capture.sv
// Bench for mfp_heartbeat_capture at 10 cycles/ms, refractory 5 ms, timeout 50 ms, depth 8.
// Pulses are launched so the accepted-beat edge falls mid-way between ms ticks.
module tb_mfp_heartbeat_capture;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        SENSOR_PULSE = 1'b0;
  logic        IO_READ_ACK = 1'b0;
  logic [31:0] IO_HEARTBEAT;
  logic        IO_READ_RDY;
  logic        BEAT_LED;
  logic        OVERFLOW;

  int checks = 0;
  int errors = 0;
  int cyc;

  mfp_heartbeat_capture #(
    .CLK_HZ    (10_000),
    .REFRACT_MS(5),
    .TIMEOUT_MS(50),
    .FIFO_DEPTH(8)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .SENSOR_PULSE(SENSOR_PULSE),
    .IO_HEARTBEAT(IO_HEARTBEAT),
    .IO_READ_RDY (IO_READ_RDY),
    .IO_READ_ACK (IO_READ_ACK),
    .BEAT_LED    (BEAT_LED),
    .OVERFLOW    (OVERFLOW)
  );

  always #5 HCLK = ~HCLK;

  // Edges counted since the last reset edge.
  always @(posedge HCLK) begin
    if (HRESET) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int          mid_ms;    // extra pulse inside the refractory window, -1 for none
    int          sec_ms;
    int          sec_off;   // extra cycles of delay on the second pulse
    logic        exp_rdy;
    logic [31:0] exp_head;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    HRESET       = 1'b1;
    SENSOR_PULSE = 1'b0;
    IO_READ_ACK  = 1'b0;
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge HCLK);
  endtask

  // Drive the pin high just before edge 'start'; the beat is acted on at edge start+3.
  task automatic pulse_at(input int start);
    if (cyc > start - 1) begin
      checks++;
      errors++;
      $display("FAIL pulse_schedule actual=%0d required<=%0d", cyc, start - 1);
    end
    wait_cyc(start - 1);
    SENSOR_PULSE = 1'b1;
    repeat (3) @(negedge HCLK);
    SENSOR_PULSE = 1'b0;
  endtask

  task automatic ack();
    IO_READ_ACK = 1'b1;
    @(negedge HCLK);
    IO_READ_ACK = 1'b0;
    @(negedge HCLK);
  endtask

  function automatic int ms_edge(input int ms);
    return ms * 10 + 2;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=expired required=finished");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    vecs[0] = '{mid_ms: -1, sec_ms: 20, sec_off: 0, exp_rdy: 1'b1, exp_head: 32'h0000_0014};
    vecs[1] = '{mid_ms: 3,  sec_ms: 20, sec_off: 0, exp_rdy: 1'b1, exp_head: 32'h0000_0014};
    vecs[2] = '{mid_ms: -1, sec_ms: 7,  sec_off: 0, exp_rdy: 1'b1, exp_head: 32'h0000_0007};
    vecs[3] = '{mid_ms: -1, sec_ms: 4,  sec_off: 0, exp_rdy: 1'b0, exp_head: 32'h0000_0000};
    vecs[4] = '{mid_ms: -1, sec_ms: 35, sec_off: 0, exp_rdy: 1'b1, exp_head: 32'h0000_0023};
    vecs[5] = '{mid_ms: -1, sec_ms: 49, sec_off: 0, exp_rdy: 1'b1, exp_head: 32'h0000_0031};
    // Beat on the same edge as the timeout: the beat record wins.
    vecs[6] = '{mid_ms: -1, sec_ms: 49, sec_off: 6, exp_rdy: 1'b1, exp_head: 32'h0000_0032};
    // Beat one edge after the timeout: only the timeout record exists.
    vecs[7] = '{mid_ms: -1, sec_ms: 49, sec_off: 7, exp_rdy: 1'b1, exp_head: 32'h0001_0032};

    // Reset state
    do_reset();
    chk("reset_rdy", {31'd0, IO_READ_RDY}, 32'd0);
    chk("reset_head", IO_HEARTBEAT, 32'd0);
    chk("reset_led", {31'd0, BEAT_LED}, 32'd0);
    chk("reset_ovf", {31'd0, OVERFLOW}, 32'd0);

    // Table: first pulse at 0 ms, optional refractory pulse, second pulse
    for (int i = 0; i < 8; i++) begin
      do_reset();
      pulse_at(ms_edge(0));
      if (vecs[i].mid_ms >= 0) pulse_at(ms_edge(vecs[i].mid_ms));
      pulse_at(ms_edge(vecs[i].sec_ms) + vecs[i].sec_off);
      wait_cyc(ms_edge(vecs[i].sec_ms) + vecs[i].sec_off + 3);
      chk($sformatf("vec%0d_rdy", i), {31'd0, IO_READ_RDY}, {31'd0, vecs[i].exp_rdy});
      chk($sformatf("vec%0d_head", i), IO_HEARTBEAT, vecs[i].exp_head);
    end

    // Latency: RDY appears exactly on the 4th edge after the pin rises
    do_reset();
    pulse_at(ms_edge(0));
    pulse_at(ms_edge(20));
    wait_cyc(204);
    chk("lat_rdy_early", {31'd0, IO_READ_RDY}, 32'd0);
    wait_cyc(205);
    chk("lat_rdy_on_time", {31'd0, IO_READ_RDY}, 32'd1);

    // Timeout, LED stretch, WAIT_FIRST pulse adds no record
    do_reset();
    pulse_at(ms_edge(0));
    wait_cyc(6);
    chk("to_led_on", {31'd0, BEAT_LED}, 32'd1);
    wait_cyc(500);
    chk("to_rdy_before", {31'd0, IO_READ_RDY}, 32'd0);
    wait_cyc(501);
    chk("to_rdy", {31'd0, IO_READ_RDY}, 32'd1);
    chk("to_head", IO_HEARTBEAT, 32'h0001_0032);
    wait_cyc(560);
    chk("to_led_off", {31'd0, BEAT_LED}, 32'd0);
    pulse_at(ms_edge(60));
    wait_cyc(606);
    chk("wf_led_on", {31'd0, BEAT_LED}, 32'd1);
    wait_cyc(620);
    ack();
    chk("wf_single_record", {31'd0, IO_READ_RDY}, 32'd0);

    // Overflow: 10 beats without ACK
    do_reset();
    for (int b = 0; b < 10; b++) pulse_at(ms_edge(b * 20));
    wait_cyc(1806);
    chk("ovf_set", {31'd0, OVERFLOW}, 32'd1);
    chk("ovf_rdy", {31'd0, IO_READ_RDY}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf_pop%0d_head", i), IO_HEARTBEAT, {i[7:0], 8'h00, 16'h0014});
      ack();
    end
    chk("ovf_drained", {31'd0, IO_READ_RDY}, 32'd0);
    pulse_at(ms_edge(200));
    chk("ovf_still_set", {31'd0, OVERFLOW}, 32'd1);
    wait_cyc(2005);
    chk("ovf_next_head", IO_HEARTBEAT, 32'h0902_0014);
    chk("ovf_cleared", {31'd0, OVERFLOW}, 32'd0);

    // ACK held high pops once; ACK while empty is ignored
    pulse_at(ms_edge(220));
    wait_cyc(2206);
    IO_READ_ACK = 1'b1;
    repeat (20) @(negedge HCLK);
    IO_READ_ACK = 1'b0;
    @(negedge HCLK);
    chk("hold_rdy", {31'd0, IO_READ_RDY}, 32'd1);
    chk("hold_head", IO_HEARTBEAT, 32'h0A00_0014);
    ack();
    chk("hold_empty", {31'd0, IO_READ_RDY}, 32'd0);
    ack();
    chk("empty_ack_rdy", {31'd0, IO_READ_RDY}, 32'd0);
    pulse_at(ms_edge(240));
    wait_cyc(2405);
    chk("empty_ack_rdy2", {31'd0, IO_READ_RDY}, 32'd1);
    chk("empty_ack_head", IO_HEARTBEAT, 32'h0B00_0014);
    ack();
    chk("empty_ack_drain", {31'd0, IO_READ_RDY}, 32'd0);

    // Reset mid-operation flushes the queue and restarts seq
    do_reset();
    for (int b = 0; b < 4; b++) pulse_at(ms_edge(b * 20));
    wait_cyc(605);
    chk("mid_rst_pre_rdy", {31'd0, IO_READ_RDY}, 32'd1);
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    chk("mid_rst_rdy", {31'd0, IO_READ_RDY}, 32'd0);
    chk("mid_rst_head", IO_HEARTBEAT, 32'd0);
    pulse_at(ms_edge(0));
    pulse_at(ms_edge(20));
    wait_cyc(205);
    chk("mid_rst_seq", IO_HEARTBEAT, 32'h0000_0014);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
